// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO APB master: FSM state encodings and register-bank addresses.
package gpio_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [2:0] ADDR_OE = 3'd0;
    localparam logic [2:0] ADDR_PU = 3'd1;
    localparam logic [2:0] ADDR_PD = 3'd2;
    localparam logic [2:0] ADDR_A  = 3'd3;
    localparam logic [2:0] ADDR_Y  = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; 'last' remembers the most recently granted port and
// doubles as the owner of the transfer in flight.
module rr_arb2 (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       last
);

    // On a tie the port that was not served last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            last <= 1'b1;
        else if (advance && (|req))
            last <= grant[1];
    end

endmodule

// File: rtl/gpio_apb_arbiter.sv
// Two-requester APB master sharing the GPIO register bank: round-robin grant, SETUP/ACCESS
// sequencing, wait-state timeout abort and per-port done/err/rdata return.
module gpio_apb_arbiter
    import gpio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  r0_req,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_done,
    output logic                  r0_err,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_done,
    output logic                  r1_err,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_pready,
    output logic                  busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic [1:0]       state;
    logic [1:0]       req;
    logic [1:0]       grant;
    logic             owner;
    logic             advance;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign req     = {r1_req, r0_req};
    assign advance = (state == ST_IDLE) && (|req);
    assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

    rr_arb2 u_arb (
        .pclk    (pclk),
        .presetn (presetn),
        .req     (req),
        .advance (advance),
        .grant   (grant),
        .last    (owner)
    );

    // Owner is the arbiter's last-granted port, stable from SETUP until the return to IDLE.
    // A ready slave in the final allowed ACCESS cycle still completes normally.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            busy      <= 1'b0;
            tmo_cnt   <= '0;
            r0_done   <= 1'b0;
            r0_err    <= 1'b0;
            r0_rdata  <= '0;
            r1_done   <= 1'b0;
            r1_err    <= 1'b0;
            r1_rdata  <= '0;
        end else begin
            r0_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_done <= 1'b0;
            r1_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (advance) begin
                        state   <= ST_SETUP;
                        m_psel  <= 1'b1;
                        busy    <= 1'b1;
                        tmo_cnt <= '0;
                        if (grant[1]) begin
                            m_pwrite <= r1_write;
                            m_paddr  <= r1_addr;
                            m_pwdata <= r1_wdata;
                        end else if (grant[0]) begin
                            m_pwrite <= r0_write;
                            m_paddr  <= r0_addr;
                            m_pwdata <= r0_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    state     <= ST_ACCESS;
                    m_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (m_pready || tmo_hit) begin
                        state     <= ST_IDLE;
                        m_psel    <= 1'b0;
                        m_penable <= 1'b0;
                        busy      <= 1'b0;
                        if (owner) begin
                            r1_done <= 1'b1;
                            r1_err  <= !m_pready;
                            if (!m_pready)
                                r1_rdata <= '0;
                            else if (!m_pwrite)
                                r1_rdata <= m_prdata;
                        end else begin
                            r0_done <= 1'b1;
                            r0_err  <= !m_pready;
                            if (!m_pready)
                                r0_rdata <= '0;
                            else if (!m_pwrite)
                                r0_rdata <= m_prdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
